fetch_pc_unit: RTL and testbench

//   IF stage and IF/ID pipeline register of the 5-stage MIPS core. Holds the PC,

---
 rtl/fetch_pc_unit.sv | 112 +++++++++++
 tb/tb_fetch_pc_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// IF stage and IF/ID register: PC register, next-PC selection (PC+4, branch, j/jal, jr/jalr).
// Optional macro DELAY_SLOT_EN keeps the slot instruction on redirect instead of squashing it.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BrInstr,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] RegJr,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC4_D,
  output logic [31:0] PC8_D,
  output logic        Valid_D,
  output logic        PcAlignErr
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic        align_err_q, align_err_d;

  logic [31:0] pc_f4, pc_f8;
  logic [31:0] br_tgt, j_tgt, redir_tgt;
  logic        redir_req, misalign, redir_take;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return pc4 + $unsigned(off);
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                              input logic [25:0] idx);
    return {pc4_hi, idx, 2'b00};
  endfunction

  always_comb begin
    pc_f4  = pc_q + 32'd4;
    pc_f8  = pc_q + 32'd8;
    br_tgt = branch_target(pc4_q, instr_q[15:0]);
    j_tgt  = jump_target(pc4_q[31:28], instr_q[25:0]);

    // ID operands are only trusted when not stalled and the ID slot holds a real instruction;
    // Branch is gated by BrInstr so a floating comparator output cannot cause a redirect.
    redir_req = !Stall && valid_q && (JumpReg || Jump || (BrInstr && Branch));

    if (JumpReg)   redir_tgt = RegJr;
    else if (Jump) redir_tgt = j_tgt;
    else           redir_tgt = br_tgt;

    misalign   = redir_req && (redir_tgt[1:0] != 2'b00);
    redir_take = redir_req && !misalign;
  end

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    pc8_d       = pc8_q;
    valid_d     = valid_q;
    align_err_d = align_err_q | misalign;
    if (!Stall) begin
      pc_d    = redir_take ? redir_tgt : pc_f4;
      instr_d = Instr_F;
      valid_d = 1'b1;
      pc4_d   = pc_f4;
      pc8_d   = pc_f8;
`ifdef DELAY_SLOT_EN
`else
      if (redir_take) begin
        instr_d = 32'h0;
        valid_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      pc4_q       <= RESET_PC + 32'd4;
      pc8_q       <= RESET_PC + 32'd8;
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      pc8_q       <= pc8_d;
      valid_q     <= valid_d;
      align_err_q <= align_err_d;
    end
  end

  assign PC_F       = pc_q;
  assign Instr_D    = instr_q;
  assign PC4_D      = pc4_q;
  assign PC8_D      = pc8_q;
  assign Valid_D    = valid_q;
  assign PcAlignErr = align_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expectations are queued when a cycle is driven and
// checked after the edge with immediate assertions.
module tb_fetch_pc_unit;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk, reset, Stall, BrInstr, Branch, Jump, JumpReg;
  logic [31:0] RegJr, Instr_F;
  logic [31:0] PC_F, Instr_D, PC4_D, PC8_D;
  logic        Valid_D, PcAlignErr;

  int compared;
  int mismatched;

  typedef struct {
    string       tag;
    logic [31:0] pc, ins, pc4, pc8;
    logic        v, e;
  } exp_t;
  exp_t sb[$];

  logic [31:0] im [logic [31:0]];

  fetch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .BrInstr(BrInstr), .Branch(Branch),
    .Jump(Jump), .JumpReg(JumpReg), .RegJr(RegJr), .Instr_F(Instr_F),
    .PC_F(PC_F), .Instr_D(Instr_D), .PC4_D(PC4_D), .PC8_D(PC8_D),
    .Valid_D(Valid_D), .PcAlignErr(PcAlignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] im_rd(input logic [31:0] a);
    if (^a === 1'bx) return 32'h0;
    if (im.exists(a)) return im[a];
    return {16'h2400, a[15:0]};
  endfunction

  // word expected in ID right after a taken redirect whose slot was fetched from a
  function automatic logic [31:0] slot(input logic [31:0] a);
    return DS ? im_rd(a) : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, st, bi, br, j, jr,
                      input logic [31:0] rj,
                      input logic [31:0] e_pc, e_ins, e_pc4, e_pc8,
                      input logic e_v, e_e);
    exp_t x;
    reset   = rst;
    Stall   = st;
    BrInstr = bi;
    Branch  = br;
    Jump    = j;
    JumpReg = jr;
    RegJr   = rj;
    Instr_F = im_rd(PC_F);
    x.tag = tag; x.pc = e_pc; x.ins = e_ins; x.pc4 = e_pc4; x.pc8 = e_pc8;
    x.v = e_v; x.e = e_e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".PC_F"},    PC_F,    x.pc);
    chk({x.tag, ".Instr_D"}, Instr_D, x.ins);
    chk({x.tag, ".PC4_D"},   PC4_D,   x.pc4);
    chk({x.tag, ".PC8_D"},   PC8_D,   x.pc8);
    chk({x.tag, ".Valid_D"}, {31'h0, Valid_D},    {31'h0, x.v});
    chk({x.tag, ".AlignErr"}, {31'h0, PcAlignErr}, {31'h0, x.e});
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    im[32'h0000_3008] = 32'h1000_FFFE;   // beq, offset -2 words
    im[32'h0000_300C] = 32'h0C00_0C10;   // jal idx 26'h0000C10
    reset = 1'b1; Stall = 1'b0; BrInstr = 1'b0; Branch = 1'b0;
    Jump = 1'b0; JumpReg = 1'b0; RegJr = 32'h0; Instr_F = 32'h0;

    // reset and free-running fetch
    for (int i = 0; i < 3; i++)
      step("rst", 1, 0, 0, 0, 0, 0, 0, 32'h3000, 32'h0, 32'h3004, 32'h3008, 0, 0);
    step("free1", 0, 0, 0, 0, 0, 0, 0, 32'h3004, im_rd(32'h3000), 32'h3004, 32'h3008, 1, 0);
    step("free2", 0, 0, 0, 0, 0, 0, 0, 32'h3008, im_rd(32'h3004), 32'h3008, 32'h300C, 1, 0);
    step("free3", 0, 0, 0, 0, 0, 0, 0, 32'h300C, 32'h1000_FFFE, 32'h300C, 32'h3010, 1, 0);
    step("free4", 0, 0, 0, 0, 0, 0, 0, 32'h3010, 32'h0C00_0C10, 32'h3010, 32'h3014, 1, 0);

    // restart at the beq: reset, then fetch 3000..3008
    step("rst2", 1, 0, 0, 0, 0, 0, 0, 32'h3000, 32'h0, 32'h3004, 32'h3008, 0, 0);
    step("f1", 0, 0, 0, 0, 0, 0, 0, 32'h3004, im_rd(32'h3000), 32'h3004, 32'h3008, 1, 0);
    step("f2", 0, 0, 0, 0, 0, 0, 0, 32'h3008, im_rd(32'h3004), 32'h3008, 32'h300C, 1, 0);
    step("f3", 0, 0, 0, 0, 0, 0, 0, 32'h300C, 32'h1000_FFFE, 32'h300C, 32'h3010, 1, 0);
    // beq taken: 300C + (-8) = 3004
    step("beq", 0, 0, 1, 1, 0, 0, 0, 32'h3004, slot(32'h300C), 32'h3010, 32'h3014, DS, 0);
    step("f5", 0, 0, 0, 0, 0, 0, 0, 32'h3008, im_rd(32'h3004), 32'h3008, 32'h300C, 1, 0);
    step("f6", 0, 0, 0, 0, 0, 0, 0, 32'h300C, 32'h1000_FFFE, 32'h300C, 32'h3010, 1, 0);

    // stall holds everything and suppresses the redirect
    step("stall1", 0, 1, 1, 1, 0, 0, 0, 32'h300C, 32'h1000_FFFE, 32'h300C, 32'h3010, 1, 0);
    step("stall2", 0, 1, 1, 1, 0, 0, 0, 32'h300C, 32'h1000_FFFE, 32'h300C, 32'h3010, 1, 0);
    step("unstall", 0, 0, 1, 1, 0, 0, 0, 32'h3004, slot(32'h300C), 32'h3010, 32'h3014, DS, 0);
    // squashed bubble must not redirect (branch request asserted only when a bubble is in ID)
    step("bubble", 0, 0, !DS, !DS, 0, 0, 0, 32'h3008, im_rd(32'h3004), 32'h3008, 32'h300C, 1, 0);
    // Branch=X on a non-branch must be ignored
    step("brx", 0, 0, 0, 1'bx, 0, 0, 0, 32'h300C, 32'h1000_FFFE, 32'h300C, 32'h3010, 1, 0);
    step("f12", 0, 0, 0, 0, 0, 0, 0, 32'h3010, 32'h0C00_0C10, 32'h3010, 32'h3014, 1, 0);

    // jal at 300C: target {0, C10, 00} = 3040
    step("jal", 0, 0, 0, 0, 1, 0, 0, 32'h3040, slot(32'h3010), 32'h3014, 32'h3018, DS, 0);
    step("f14", 0, 0, 0, 0, 0, 0, 0, 32'h3044, im_rd(32'h3040), 32'h3044, 32'h3048, 1, 0);
    // JumpReg beats Jump (JTgt here would be 0000_C100)
    step("jrj", 0, 0, 0, 0, 1, 1, 32'h3200, 32'h3200, slot(32'h3044), 32'h3048, 32'h304C, DS, 0);
    step("f16", 0, 0, 0, 0, 0, 0, 0, 32'h3204, im_rd(32'h3200), 32'h3204, 32'h3208, 1, 0);

    // misaligned jr is dropped and latches the sticky error
    step("jrbad", 0, 0, 0, 0, 0, 1, 32'h3002, 32'h3208, im_rd(32'h3204), 32'h3208, 32'h320C, 1, 1);
    step("f18", 0, 0, 0, 0, 0, 0, 0, 32'h320C, im_rd(32'h3208), 32'h320C, 32'h3210, 1, 1);
    step("jrok", 0, 0, 0, 0, 0, 1, 32'h3100, 32'h3100, slot(32'h320C), 32'h3210, 32'h3214, DS, 1);
    step("f20", 0, 0, 0, 0, 0, 0, 0, 32'h3104, im_rd(32'h3100), 32'h3104, 32'h3108, 1, 1);

    // PC wrap at the top of the address space
    step("jrtop", 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, slot(32'h3104), 32'h3108, 32'h310C, DS, 1);
    step("wrap", 0, 0, 0, 0, 0, 0, 0, 32'h0, im_rd(32'hFFFF_FFFC), 32'h0, 32'h4, 1, 1);
    step("f23", 0, 0, 0, 0, 0, 0, 0, 32'h4, im_rd(32'h0), 32'h4, 32'h8, 1, 1);

    // reset beats a taken branch and clears the sticky error
    step("rstbr", 1, 0, 1, 1, 0, 0, 0, 32'h3000, 32'h0, 32'h3004, 32'h3008, 0, 0);
    step("f25", 0, 0, 0, 0, 0, 0, 0, 32'h3004, im_rd(32'h3000), 32'h3004, 32'h3008, 1, 0);
    // reset beats stall
    step("rststl", 1, 1, 0, 0, 0, 0, 0, 32'h3000, 32'h0, 32'h3004, 32'h3008, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
